// File: rtl/img1bit_pkg.sv
// Shared constants and FSM encoding for the 1-bit morphological pipeline.
package img1bit_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    IN_FRAME   = 2'd1,
    REPORT     = 2'd2
  } bbox_state_e;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int CW_DEF    = 11;

endpackage

// File: rtl/sync_edge_det.sv
// Registers a 1-bit level and emits single-cycle rise/fall pulses.
module sync_edge_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_d;
  logic primed;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sig_d  <= 1'b0;
      primed <= 1'b0;
    end else begin
      sig_d  <= sig;
      primed <= 1'b1;
    end
  end

  // No edges in the first cycle after reset, so a level that was already
  // high when reset released is not mistaken for a fresh rise.
  assign rise = primed & sig & ~sig_d;
  assign fall = primed & ~sig & sig_d;

endmodule

// File: rtl/img1bit_bbox_detect.sv
// Per-frame foreground bounding box and pixel count for the 1-bit stream.
// Optional macro BBOX_MIN_PIXELS_EN gates obj_found on a MIN_PIXELS threshold.
module img1bit_bbox_detect
  import img1bit_pkg::*;
#(
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int CW         = CW_DEF,
  parameter int PW         = 20,
  parameter int MIN_PIXELS = 16
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          wr_en,
  input  logic          img_1bit_in,
  input  logic          pre_href,
  input  logic          pre_vsync,
  output logic [CW-1:0] box_x_min,
  output logic [CW-1:0] box_x_max,
  output logic [CW-1:0] box_y_min,
  output logic [CW-1:0] box_y_max,
  output logic [PW-1:0] pix_cnt,
  output logic          obj_found,
  output logic          box_valid
);

  localparam logic [CW-1:0] X_LIM   = CW'(IMG_W);
  localparam logic [CW-1:0] Y_LIM   = CW'(IMG_H);
  localparam logic [PW-1:0] CNT_MAX = '1;

  logic vs_rise, vs_fall, hs_rise, hs_fall;

  sync_edge_det u_vs_edge (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .sig      (pre_vsync),
    .rise     (vs_rise),
    .fall     (vs_fall)
  );

  sync_edge_det u_hs_edge (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .sig      (pre_href),
    .rise     (hs_rise),
    .fall     (hs_fall)
  );

  bbox_state_e   state;
  logic [CW-1:0] x_cnt, y_cnt;
  logic [CW-1:0] xmin, xmax, ymin, ymax;
  logic [PW-1:0] cnt;
  logic          any;
  logic [CW-1:0] x_cur;
  logic          x_in, fg, obj;

  // Line start re-aligns the column, so a stray pixel before the line
  // cannot skew the first real column.
  assign x_cur = hs_rise ? '0 : x_cnt;
  assign x_in  = (x_cur < X_LIM);
  assign fg    = wr_en & img_1bit_in & x_in & (y_cnt < Y_LIM);

`ifdef BBOX_MIN_PIXELS_EN
  assign obj = any & (cnt >= PW'(MIN_PIXELS));
`else
  assign obj = any;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= WAIT_FRAME;
      x_cnt     <= '0;
      y_cnt     <= '0;
      xmin      <= '1;
      ymin      <= '1;
      xmax      <= '0;
      ymax      <= '0;
      cnt       <= '0;
      any       <= 1'b0;
      box_x_min <= '0;
      box_x_max <= '0;
      box_y_min <= '0;
      box_y_max <= '0;
      pix_cnt   <= '0;
      obj_found <= 1'b0;
      box_valid <= 1'b0;
    end else begin
      box_valid <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (vs_rise) begin
            state <= IN_FRAME;
            x_cnt <= '0;
            y_cnt <= '0;
            xmin  <= '1;
            ymin  <= '1;
            xmax  <= '0;
            ymax  <= '0;
            cnt   <= '0;
            any   <= 1'b0;
          end
        end
        IN_FRAME: begin
          if (vs_fall) begin
            // Outputs land here so they are visible during the REPORT cycle.
            state     <= REPORT;
            box_x_min <= obj ? xmin : '0;
            box_x_max <= obj ? xmax : '0;
            box_y_min <= obj ? ymin : '0;
            box_y_max <= obj ? ymax : '0;
            pix_cnt   <= cnt;
            obj_found <= obj;
            box_valid <= 1'b1;
          end else begin
            if (fg) begin
              if (x_cur < xmin) xmin <= x_cur;
              if (x_cur > xmax) xmax <= x_cur;
              if (y_cnt < ymin) ymin <= y_cnt;
              if (y_cnt > ymax) ymax <= y_cnt;
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
              any <= 1'b1;
            end
            if (hs_fall) begin
              x_cnt <= '0;
              if (y_cnt < Y_LIM) y_cnt <= y_cnt + 1'b1;
            end else if (wr_en && x_in) begin
              x_cnt <= x_cur + 1'b1;
            end else begin
              x_cnt <= x_cur;
            end
          end
        end
        REPORT:  state <= WAIT_FRAME;
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_img1bit_bbox_detect.sv
// Directed frames against a pixel-list bounding-box model plus literal checks.
module tb_img1bit_bbox_detect;

  localparam int CW    = 11;
  localparam int PW    = 20;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          img_1bit_in = 1'b0;
  logic          pre_href = 1'b0;
  logic          pre_vsync = 1'b0;
  logic [CW-1:0] box_x_min, box_x_max, box_y_min, box_y_max;
  logic [PW-1:0] pix_cnt;
  logic          obj_found, box_valid;

  img1bit_bbox_detect #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .PW(PW), .MIN_PIXELS(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .wr_en      (wr_en),
    .img_1bit_in(img_1bit_in),
    .pre_href   (pre_href),
    .pre_vsync  (pre_vsync),
    .box_x_min  (box_x_min),
    .box_x_max  (box_x_max),
    .box_y_min  (box_y_min),
    .box_y_max  (box_y_max),
    .pix_cnt    (pix_cnt),
    .obj_found  (obj_found),
    .box_valid  (box_valid)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Frame model: plain min/max/count over the foreground pixels the bench drives.
  int m_xmin, m_xmax, m_ymin, m_ymax, m_cnt;
  bit m_any;
  int row;
  // Pending report and currently expected held outputs.
  int p_xmin, p_xmax, p_ymin, p_ymax, p_cnt;
  bit p_obj;
  int e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_cnt = 0;
  bit e_obj = 1'b0;
  int pend_cyc = -1;
  bit chk_en = 1'b0;
  bit ebv;

  task automatic model_clear();
    m_xmin = 1 << 30; m_ymin = 1 << 30; m_xmax = -1; m_ymax = -1;
    m_cnt = 0; m_any = 1'b0; row = 0;
  endtask

  task automatic model_pix(int x, int y, bit we, bit v);
    if (we && v && x < IMG_W && y < IMG_H) begin
      if (x < m_xmin) m_xmin = x;
      if (x > m_xmax) m_xmax = x;
      if (y < m_ymin) m_ymin = y;
      if (y > m_ymax) m_ymax = y;
      if (m_cnt < (1 << PW) - 1) m_cnt++;
      m_any = 1'b1;
    end
  endtask

  task automatic model_report();
    bit obj;
    obj = m_any;
`ifdef BBOX_MIN_PIXELS_EN
    obj = m_any && (m_cnt >= 16);
`endif
    p_obj  = obj;
    p_cnt  = m_cnt;
    p_xmin = obj ? m_xmin : 0;
    p_xmax = obj ? m_xmax : 0;
    p_ymin = obj ? m_ymin : 0;
    p_ymax = obj ? m_ymax : 0;
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      ebv = (cyc == pend_cyc) && sys_rst_n;
      if (ebv) begin
        e_xmin = p_xmin; e_xmax = p_xmax; e_ymin = p_ymin; e_ymax = p_ymax;
        e_cnt = p_cnt; e_obj = p_obj;
      end
      n_vec++;
      if ({box_valid, obj_found, box_x_min, box_x_max, box_y_min, box_y_max, pix_cnt} !==
          {ebv, e_obj, CW'(e_xmin), CW'(e_xmax), CW'(e_ymin), CW'(e_ymax), PW'(e_cnt)}) begin
        n_err++;
        $display("FAIL cycle %0d: dut v=%0b obj=%0b box=(%0d,%0d,%0d,%0d) cnt=%0d, model v=%0b obj=%0b box=(%0d,%0d,%0d,%0d) cnt=%0d",
                 cyc, box_valid, obj_found, box_x_min, box_x_max, box_y_min, box_y_max, pix_cnt,
                 ebv, e_obj, e_xmin, e_xmax, e_ymin, e_ymax, e_cnt);
      end
    end
  end

  task automatic check_lit(string nm, bit bv, int xmn, int xmx, int ymn, int ymx, int cn, bit ob);
    n_vec++;
    if (box_valid !== bv || obj_found !== ob || box_x_min !== CW'(xmn) || box_x_max !== CW'(xmx) ||
        box_y_min !== CW'(ymn) || box_y_max !== CW'(ymx) || pix_cnt !== PW'(cn)) begin
      n_err++;
      $display("FAIL %s: got v=%0b obj=%0b box=(%0d,%0d,%0d,%0d) cnt=%0d, want v=%0b obj=%0b box=(%0d,%0d,%0d,%0d) cnt=%0d",
               nm, box_valid, obj_found, box_x_min, box_x_max, box_y_min, box_y_max, pix_cnt,
               bv, ob, xmn, xmx, ymn, ymx, cn);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive(bit vs, bit hs, bit we, bit v);
    pre_vsync = vs; pre_href = hs; wr_en = we; img_1bit_in = v;
  endtask

  task automatic frame_begin();
    drive(1, 0, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    model_clear();
  endtask

  // One line of len pixels, foreground on x0..x1; junk = img high without wr_en on the href-low cycle.
  task automatic line(int x0, int x1, int len, bit junk);
    for (int x = 0; x < len; x++) begin
      drive(1, 1, 1, (x >= x0 && x <= x1));
      model_pix(x, row, 1'b1, (x >= x0 && x <= x1));
      tick();
    end
    drive(1, 0, 0, junk);
    tick();
    row++;
  endtask

  // Drives the vsync-fall cycle F (with a pixel that must be ignored); returns in F+1.
  task automatic frame_end(bit expect_rpt);
    drive(0, 0, 1, 1);
    if (expect_rpt) begin
      model_report();
      pend_cyc = cyc + 1;
    end
    tick();
  endtask

  task automatic gap();
    drive(0, 0, 1, 1); tick();
    drive(0, 0, 0, 0);
  endtask

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    check_lit("reset_state", 0, 0, 0, 0, 0, 0, 0);
    sys_rst_n = 1'b1;
    tick(); tick();

    // Single foreground pixel at (100,50).
    frame_begin();
    for (int r = 0; r < 50; r++) line(1, 0, 1, 0);
    line(100, 100, 101, 0);
    frame_end(1);
`ifdef BBOX_MIN_PIXELS_EN
    check_lit("single_px", 1, 0, 0, 0, 0, 1, 0);
`else
    check_lit("single_px", 1, 100, 100, 50, 50, 1, 1);
`endif
    gap(); tick(); tick();

    // Rectangle x 10..209, y 20..119.
    frame_begin();
    for (int r = 0; r < 20; r++) line(1, 0, 1, 0);
    for (int r = 20; r < 120; r++) line(10, 209, 210, 0);
    frame_end(1);
    check_lit("rect", 1, 10, 209, 20, 119, 20000, 1);
    gap();
    tick();
    check_lit("rect_hold", 0, 10, 209, 20, 119, 20000, 1);

    // All-zero frame with img high only where wr_en is low.
    frame_begin();
    for (int r = 0; r < 4; r++) line(1, 0, 8, 1);
    frame_end(1);
    check_lit("all_zero", 1, 0, 0, 0, 0, 0, 0);
    gap(); tick();

    // Out of range: columns 640..649 and rows 480/481 ignored; column 639 counts.
    frame_begin();
    line(639, 649, 650, 1);
    line(1, 2, 5, 0);
    for (int r = 2; r < 480; r++) line(1, 0, 1, 0);
    line(0, 4, 5, 0);
    line(0, 4, 5, 0);
    frame_end(1);
`ifdef BBOX_MIN_PIXELS_EN
    check_lit("range", 1, 0, 0, 0, 0, 3, 0);
`else
    check_lit("range", 1, 1, 639, 0, 1, 3, 1);
`endif
    gap(); tick();

    // Reset in the middle of row 200; the rest of that frame must not report.
    frame_begin();
    for (int r = 0; r < 200; r++) line(1, (r == 10) ? 1 : 0, 3, 0);
    for (int x = 0; x < 5; x++) begin drive(1, 1, 1, 1); tick(); end
    sys_rst_n = 1'b0;
    e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0; e_obj = 1'b0;
    pend_cyc = -1;
    tick();
    check_lit("reset_mid", 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    sys_rst_n = 1'b1;
    for (int x = 0; x < 5; x++) begin drive(1, 1, 1, 1); tick(); end
    drive(1, 0, 0, 0); tick();
    line(0, 3, 4, 0);
    frame_end(0);
    check_lit("aborted_frame", 0, 0, 0, 0, 0, 0, 0);
    gap(); tick();

    // Clean frame after the abort: pixel at (5,5).
    frame_begin();
    for (int r = 0; r < 5; r++) line(1, 0, 2, 0);
    line(5, 5, 6, 0);
    frame_end(1);
`ifdef BBOX_MIN_PIXELS_EN
    check_lit("after_reset", 1, 0, 0, 0, 0, 1, 0);
`else
    check_lit("after_reset", 1, 5, 5, 5, 5, 1, 1);
`endif
    gap(); tick();

    // Back-to-back frames, exactly two vsync-low cycles apart.
    frame_begin();
    line(1, 0, 1, 0);
    line(1, 0, 1, 0);
    line(7, 30, 31, 0);
    line(7, 30, 31, 0);
    frame_end(1);
    check_lit("frame_a", 1, 7, 30, 2, 3, 48, 1);
    gap();
    frame_begin();
    line(1, 0, 1, 0);
    line(0, 19, 20, 0);
    frame_end(1);
    check_lit("frame_b", 1, 0, 19, 1, 1, 20, 1);
    gap();
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/img1bit_bbox_detect.md
# img1bit_bbox_detect

Per-frame bounding-box extractor for the 1-bit morphological pipeline. It sits directly downstream of the 1-bit erosion/dilation stages and consumes their `img_1bit_out` / `wr_en` / `href` / `vsync` stream. It tracks the min/max column and row of all foreground (`1`) pixels in each frame and counts them. At end of frame it publishes the box with a one-cycle valid pulse for the moving-object overlay and mode-switch logic.

## Interface
- `IMG_W`, default 640: active pixels per line.
- `IMG_H`, default 480: active lines per frame.
- `CW`, default 11: coordinate width; must satisfy 2^CW > max(IMG_W, IMG_H).
- `PW`, default 20: foreground pixel-count width.
- `MIN_PIXELS`, default 16: noise threshold; used only when `BBOX_MIN_PIXELS_EN` is defined.
- `sys_clk`, in, 1: single clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: pixel valid.
- `img_1bit_in`, in, 1: pixel value; 1 is foreground.
- `pre_href`, in, 1: line active, high.
- `pre_vsync`, in, 1: frame active, high.
- `box_x_min`, out, CW: leftmost foreground column. Reset value 0.
- `box_x_max`, out, CW: rightmost foreground column. Reset value 0.
- `box_y_min`, out, CW: topmost foreground row. Reset value 0.
- `box_y_max`, out, CW: bottom foreground row. Reset value 0.
- `pix_cnt`, out, PW: foreground pixels in the last frame, saturating. Reset value 0.
- `obj_found`, out, 1: last frame contained a valid object. Reset value 0.
- `box_valid`, out, 1: one-cycle pulse when the outputs above update. Reset value 0.

## Operation
- Edge detect uses a registered copy of each input:
  - vsync rise/fall is derived from `vsync_d` vs `pre_vsync`.
  - href fall is derived from `href_d` vs `pre_href`.
- State machine:
  - **WAIT_FRAME** (after reset): ignore all pixels. On a vsync rise, go to IN_FRAME. Any frame already in progress at reset is discarded.
  - **IN_FRAME**:
    - On entry, clear the accumulators: x_cnt=0, y_cnt=0, cnt=0, xmin=ymin=all-ones, xmax=ymax=0, any=0.
    - On a vsync fall, go to REPORT.
  - **REPORT**: one cycle. Latch the outputs, pulse `box_valid`, then go to WAIT_FRAME.
- Column counter `x_cnt`:
  - Increments on each `wr_en` in IN_FRAME.
  - Clears on an href fall.
  - Saturates at IMG_W; a pixel with x_cnt ≥ IMG_W is ignored.
- Row counter `y_cnt`:
  - Increments on each href fall in IN_FRAME.
  - Saturates at IMG_H; rows ≥ IMG_H are ignored.
- A pixel is foreground when `wr_en & img_1bit_in` and it is in range. For each foreground pixel:
  - update xmin, xmax, ymin, ymax by comparing against (x_cnt, y_cnt);
  - set `any`=1;
  - increment `cnt`, saturating at 2^PW−1.
- The pixel on the vsync-fall cycle is not counted. Pixels arriving while in REPORT or WAIT_FRAME are dropped.
- Latch rule in REPORT:
  - If `any`=0, all coordinates are 0, `obj_found`=0, and `pix_cnt` is 0.
  - Otherwise, the coordinates are the accumulators and `obj_found`=1.
- Outputs hold between reports.
- An href fall coinciding with a vsync fall: the row increment is ignored, and the vsync fall wins.
- Asserting reset mid-frame clears all outputs immediately. No report is produced for that frame.

## Timing
- Pipeline latency: a pixel sampled in cycle N updates the accumulators at the edge ending cycle N.
- The first cycle with `pre_vsync`=0 after a high is cycle F. `box_valid`=1 and the new outputs are visible in cycle F+1; `box_valid` is back to 0 in F+2.
- Back-to-back frames need ≥ 2 vsync-low cycles between them; a vsync rise during REPORT is missed.
- Throughput: one pixel per clock. All compares are registered in a single stage.

## Configuration
- `BBOX_MIN_PIXELS_EN` defined: in REPORT, `obj_found`=1 only if `any` and cnt ≥ MIN_PIXELS. Otherwise, the coordinates report 0, but `pix_cnt` still reports cnt.
- Not defined: `obj_found`=`any`, MIN_PIXELS is unused, and the comparator is not built.

## Structure
- A shared package `img1bit_pkg` holds:
  - FSM state encoding: WAIT_FRAME=2'd0, IN_FRAME=2'd1, REPORT=2'd2;
  - default IMG_W, IMG_H, CW constants, shared with the erosion/dilation stages.
- One sub-module, `sync_edge_det`: registers a 1-bit signal and outputs rise/fall pulses. It is instanced for vsync and href.

## Test plan
- 640×480 frame, single foreground pixel at (100,50) → one `box_valid` pulse at F+1. Expect x_min=x_max=100, y_min=y_max=50, pix_cnt=1, `obj_found`=1 (`obj_found`=0 with `BBOX_MIN_PIXELS_EN`).
- Rectangle of 1s covering x 10..209, y 20..119 → box (10,209,20,119), pix_cnt=20000, `obj_found`=1 in both configs.
- All-zero frame → all coordinates 0, pix_cnt=0, `obj_found`=0, `box_valid` still pulses once.
- Reset asserted mid-frame at row 200, released, then a full frame with pixel at (5,5) → outputs 0 during the aborted frame. First `box_valid` reports (5,5,5,5), with no report for the partial frame.
- Foreground on `wr_en` beyond column 639, plus `img_1bit_in`=1 with `wr_en`=0 → both ignored. Box reflects only the in-range valid pixels.
- Two consecutive frames with different objects, vsync low for 2 cycles between them → two pulses. Second report is independent of the first (accumulators cleared).
